// File: rtl/shift_arbiter_2ch_pkg.sv
// Shared types and constants for the two-channel shift arbiter.
package shift_arbiter_2ch_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned AMT_W  = 3;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              lr;
      logic [AMT_W-1:0]  n;
   } shift_op_t;

   // Selects the operand bundle of the winning requester.
   function automatic shift_op_t pick_op(input logic sel, input shift_op_t op0, input shift_op_t op1);
      return sel ? op1 : op0;
   endfunction

endpackage

// File: rtl/shift_arbiter_2ch_if.sv
// Requester, consumer and status signals of the two-channel shift arbiter.
interface shift_arbiter_2ch_if;
   import shift_arbiter_2ch_pkg::*;

   logic              req0;
   logic [DATA_W-1:0] in0;
   logic              lr0;
   logic [AMT_W-1:0]  n0;
   logic              req1;
   logic [DATA_W-1:0] in1;
   logic              lr1;
   logic [AMT_W-1:0]  n1;
   logic              gnt0;
   logic              gnt1;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_id;
   logic              out_ready;
   logic              busy;

   modport slave (
      input  req0, in0, lr0, n0, req1, in1, lr1, n1, out_ready,
      output gnt0, gnt1, out_valid, out_data, out_id, busy
   );

   modport master (
      output req0, in0, lr0, n0, req1, in1, lr1, n1, out_ready,
      input  gnt0, gnt1, out_valid, out_data, out_id, busy
   );

endinterface

// File: rtl/barrel_shifter_8bit.sv
// Combinational 8-bit logical barrel shifter; zeros fill vacated bits.
module barrel_shifter_8bit
   import shift_arbiter_2ch_pkg::*;
(
   output logic [DATA_W-1:0] out,
   input  logic [DATA_W-1:0] in,
   input  logic              lr,
   input  logic [AMT_W-1:0]  n
);

   always_comb begin
      out = '0;
      case (lr)
         DIR_LEFT:  out = in << n;
         DIR_RIGHT: out = in >> n;
      endcase
   end

endmodule

// File: rtl/shift_arbiter_2ch.sv
// Round-robin arbiter and sequencer in front of the shared barrel shifter.
module shift_arbiter_2ch
   import shift_arbiter_2ch_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   shift_arbiter_2ch_if.slave  bus
);

   state_e            state_q;
   logic              prio_q;
   logic              win_q;
   shift_op_t         op_q;
   logic              gnt0_q;
   logic              gnt1_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              id_q;
   logic              busy_q;

   shift_op_t         op0_d;
   shift_op_t         op1_d;
   logic              any_req_d;
   logic              win_d;
   logic [DATA_W-1:0] shift_out;

   assign op0_d     = '{data: bus.in0, lr: bus.lr0, n: bus.n0};
   assign op1_d     = '{data: bus.in1, lr: bus.lr1, n: bus.n1};
   assign any_req_d = bus.req0 | bus.req1;
   // A lone requester wins outright; a tie goes to the priority holder.
   assign win_d     = (bus.req0 & bus.req1) ? prio_q : bus.req1;

   barrel_shifter_8bit u_shifter (
      .out (shift_out),
      .in  (op_q.data),
      .lr  (op_q.lr),
      .n   (op_q.n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         prio_q  <= RR_INIT;
         win_q   <= 1'b0;
         op_q    <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req_d) begin
                  op_q    <= pick_op(win_d, op0_d, op1_d);
                  win_q   <= win_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  prio_q  <= ~win_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               data_q  <= shift_out;
               id_q    <= win_q;
               valid_q <= 1'b1;
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_id    = id_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_arbiter_2ch.sv
// Scoreboard bench for shift_arbiter_2ch: directed requests, decoupled result monitor.
module tb_shift_arbiter_2ch;
   import shift_arbiter_2ch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_arbiter_2ch_if bus ();

   shift_arbiter_2ch #(.RR_INIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] sb_q[$];
   int         gnt_log[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: grant exclusivity/order logging and result comparison against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.gnt0 | bus.gnt1) begin
            check("gnt_exclusive", 16'(bus.gnt0 & bus.gnt1), 16'd0);
            if (bus.gnt0) gnt_log.push_back(0);
            if (bus.gnt1) gnt_log.push_back(1);
         end
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: got id %0d data %h, expected no response",
                        bus.out_id, bus.out_data);
            end else begin
               check("result", 16'({bus.out_id, bus.out_data}), 16'(sb_q[0]));
               if (bus.out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic set_req0(input logic [7:0] d, input logic lr, input logic [2:0] n);
      bus.req0 = 1'b1; bus.in0 = d; bus.lr0 = lr; bus.n0 = n;
   endtask

   task automatic set_req1(input logic [7:0] d, input logic lr, input logic [2:0] n);
      bus.req1 = 1'b1; bus.in1 = d; bus.lr1 = lr; bus.n1 = n;
   endtask

   task automatic expect_rsp(input logic id, input logic [7:0] d);
      sb_q.push_back({id, d});
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req0      = 1'b0;
      bus.req1      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      gnt_log.delete();
   endtask

   // Drives requests until n_grants grants are seen and every expected result is drained.
   task automatic run(input int n_grants, input bit hold, input int stall);
      int grants    = 0;
      int stall_cnt = 0;
      int cyc       = 0;
      bit done      = 1'b0;
      bus.out_ready = (stall == 0);
      while (!done) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.gnt0 | bus.gnt1) grants++;
         if (bus.gnt0 && !hold) bus.req0 = 1'b0;
         if (bus.gnt1 && !hold) bus.req1 = 1'b0;
         if (grants >= n_grants) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end
         if (bus.out_valid) begin
            if (stall_cnt < stall) begin
               bus.out_ready = 1'b0;
               stall_cnt++;
            end else begin
               bus.out_ready = 1'b1;
            end
         end else begin
            stall_cnt     = 0;
            bus.out_ready = (stall == 0);
         end
         if (grants >= n_grants && !bus.busy && sb_q.size() == 0) begin
            done = 1'b1;
         end else if (cyc >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d grants, %0d results pending, expected %0d grants, 0 pending",
                     grants, sb_q.size(), n_grants);
            done = 1'b1;
         end
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic check_gnts(input int cnt, input logic [3:0] ids);
      check("gnt_count", 16'(gnt_log.size()), 16'(cnt));
      for (int i = 0; i < cnt; i++) begin
         if (i < gnt_log.size()) check("gnt_order", 16'(gnt_log[i]), 16'(ids[i]));
      end
      gnt_log.delete();
   endtask

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b0; bus.in0 = '0; bus.lr0 = 1'b0; bus.n0 = '0;
      bus.req1 = 1'b0; bus.in1 = '0; bus.lr1 = 1'b0; bus.n1 = '0;
      bus.out_ready = 1'b1;
      do_reset();

      // Reset values held while idle.
      repeat (5) begin
         @(negedge clk);
         check("reset_vals", 16'({bus.out_valid, bus.busy, bus.gnt0, bus.gnt1, bus.out_id, bus.out_data}), 16'd0);
      end

      // Single left shift with exact latency.
      @(posedge clk);
      #1;
      set_req0(8'hB5, DIR_LEFT, 3'd3);
      expect_rsp(1'b0, 8'hA8);
      @(negedge clk);
      check("gnt0_not_yet", 16'(bus.gnt0), 16'd0);
      @(negedge clk);
      check("gnt0_cycle", 16'({bus.gnt0, bus.gnt1, bus.busy, bus.out_valid}), 16'b1010);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("valid_cycle", 16'({bus.gnt0, bus.out_valid}), 16'b01);
      @(negedge clk);
      check("back_idle", 16'({bus.out_valid, bus.busy}), 16'd0);
      check_gnts(1, 4'b0000);

      // Both requesting after reset, consumer stalled 3 cycles per result.
      do_reset();
      set_req0(8'h81, DIR_RIGHT, 3'd1);
      set_req1(8'h0F, DIR_LEFT, 3'd4);
      expect_rsp(1'b0, 8'h40);
      expect_rsp(1'b1, 8'hF0);
      run(2, 1'b0, 3);
      check_gnts(2, 4'b0010);

      // Requests held continuously: grants alternate 0,1,0,1.
      do_reset();
      set_req0(8'h80, DIR_RIGHT, 3'd7);
      set_req1(8'h5A, DIR_LEFT, 3'd0);
      for (int i = 0; i < 2; i++) begin
         expect_rsp(1'b0, 8'h01);
         expect_rsp(1'b1, 8'h5A);
      end
      run(4, 1'b1, 0);
      check_gnts(4, 4'b1010);

      // Zero and maximum shift amounts.
      set_req0(8'h5A, DIR_LEFT, 3'd0);
      expect_rsp(1'b0, 8'h5A);
      run(1, 1'b0, 0);
      set_req1(8'h5A, DIR_RIGHT, 3'd0);
      expect_rsp(1'b1, 8'h5A);
      run(1, 1'b0, 0);
      set_req1(8'h80, DIR_RIGHT, 3'd7);
      expect_rsp(1'b1, 8'h01);
      run(1, 1'b0, 0);
      check_gnts(3, 4'b0110);

      // Reset during SHIFT drops the transaction and restores priority.
      do_reset();
      set_req0(8'h81, DIR_RIGHT, 3'd1);
      expect_rsp(1'b0, 8'h40);
      run(1, 1'b0, 0);
      set_req0(8'hFF, DIR_LEFT, 3'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.gnt0) break;
      end
      check("midop_gnt0", 16'(bus.gnt0), 16'd1);
      rst      = 1'b1;
      bus.req0 = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midop_reset", 16'({bus.out_valid, bus.busy, bus.gnt0, bus.gnt1, bus.out_id, bus.out_data}), 16'd0);
      @(negedge clk);
      check("midop_idle", 16'({bus.out_valid, bus.busy}), 16'd0);
      gnt_log.delete();
      set_req0(8'hC3, DIR_LEFT, 3'd1);
      set_req1(8'h3C, DIR_RIGHT, 3'd2);
      expect_rsp(1'b0, 8'h86);
      expect_rsp(1'b1, 8'h0F);
      run(2, 1'b0, 0);
      check_gnts(2, 4'b0010);

      check("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/shift_arbiter_2ch.md
# shift_arbiter_2ch

Two-requester arbiter and sequencer for the shared 8-bit logical barrel shifter. Each requester presents an operand, direction and shift amount. The block grants one requester at a time under round-robin priority, latches its operands and drives them through the shifter core. It then holds the registered result with a valid/ready handshake until the consumer accepts it. The block sits between the datapath requesters and the single shifter instance.

## Interface
- `RR_INIT`, default 0: requester holding priority after reset (0 or 1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 wants a shift; held until `gnt0`.
- `in0` input 8: requester 0 operand.
- `lr0` input 1: requester 0 direction; 1 = shift left, 0 = shift right.
- `n0` input 3: requester 0 shift amount, 0–7.
- `req1`, `in1`, `lr1`, `n1`: same as above for requester 1.
- `gnt0` / `gnt1` output 1 each: one-cycle grant pulse; operands were captured on the preceding edge.
- `out_valid` output 1: result available.
- `out_data` output 8: shifted result.
- `out_id` output 1: index of the requester that owns `out_data`.
- `out_ready` input 1: consumer accepts the result when high together with `out_valid`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, SHIFT, RESP.
- **IDLE:**
  - req0/req1 are sampled only in this state.
  - If any req is high on a clock edge: pick the winner, latch its in/lr/n, pulse its gnt in the next cycle, go to SHIFT.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - Only one req high: that requester wins.
  - Both high: the requester holding priority wins.
  - After every grant, priority passes to the other requester.
  - Priority is not updated while idle.
- **SHIFT:**
  - Latched operands drive the shifter core.
  - On the edge: register the core output into `out_data` and the winner index into `out_id`, go to RESP.
- **RESP:**
  - `out_valid` = 1. `out_data` and `out_id` are stable.
  - On an edge with `out_ready` = 1: clear `out_valid` and go to IDLE.
  - Otherwise hold.
- **Shift arithmetic:** logical shift, zeros fill the vacated bits, bits shifted out are discarded, n = 0 passes the operand through.
- **Requester rule:** a requester must deassert or change req/operands only after seeing its gnt. A req still high while the FSM is in IDLE is treated as a new request.
- **Reset:** `rst` high on any edge, including mid-SHIFT or mid-RESP, forces:
  - state = IDLE, priority = RR_INIT;
  - `gnt0` = `gnt1` = 0, `out_valid` = 0, `out_data` = 8'h00, `out_id` = 0, `busy` = 0;
  - the in-flight transaction is dropped without a response.

## Timing
- Request sampled in IDLE at edge t → gnt high during cycle t+1 (state SHIFT) → `out_valid` high from cycle t+2.
- Minimum request-to-valid latency: 2 cycles.
- If `out_ready` is already high when `out_valid` rises: `out_valid` lasts one cycle, IDLE in cycle t+3, and the next grant appears in cycle t+4.
- Peak throughput: one transaction per 3 cycles.
- `out_ready` low stalls in RESP indefinitely. Pending requests wait and lose no state.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2;
  - direction constants: DIR_LEFT = 1, DIR_RIGHT = 0;
  - data width (8) and shift-amount width (3).
- One sub-module: the existing `barrel_shifter_8bit` combinational core (out, in, lr, n), instantiated once and fed from the latched operand registers.
- Arbitration and FSM live in the top.

## Test plan
- **Reset values:** reset, then idle 5 cycles → outputs stay at reset values, `busy` = 0.
- **Single left shift:** req0, in0 = 8'hB5, lr0 = 1, n0 = 3 → `gnt0` pulse 1 cycle later; `out_valid` next cycle with `out_data` = 8'hA8, `out_id` = 0.
- **Round-robin with stalled consumer:** RR_INIT = 0; both requesting, req0 (8'h81, right, 1), req1 (8'h0F, left, 4); `out_ready` held low 3 cycles.
  - Grant order is 0 then 1.
  - Results are 8'h40 (id 0) then 8'hF0 (id 1).
  - `out_data` stays stable during the stall.
- **Priority alternation:** both req held continuously for 4 transactions → grant sequence 0, 1, 0, 1. `gnt0` and `gnt1` are never high together.
- **Zero and maximum shift:** n = 0 with 8'h5A either direction → 8'h5A. n = 7, right, 8'h80 → 8'h01.
- **Reset mid-operation:** assert `rst` during SHIFT → next cycle `out_valid` = 0, state IDLE, priority back to RR_INIT. A subsequent req1 completes normally.
